alu_cmd_issuer: RTL

//  Upstream command stage of the ALU. Buffers operand/opcode commands in a FIFO and presents one command
//  at a time on ALU_A/ALU_B/ALU_FUN, holding them stable for the registered decoder and units. After a

---
 rtl/alu_cmd_issuer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_issuer.sv
// Command issuer for the ALU: buffers commands in a FIFO and issues one at a time, then returns the result.
// Optional ALU_CMD_FLUSH_EN adds a FLUSH input that empties the command FIFO.
module alu_cmd_issuer #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
`ifdef ALU_CMD_FLUSH_EN
    input  logic                     FLUSH,
`endif
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic [WIDTH-1:0]         IN_A,
    input  logic [WIDTH-1:0]         IN_B,
    input  logic [3:0]               IN_FUN,
    output logic [WIDTH-1:0]         ALU_A,
    output logic [WIDTH-1:0]         ALU_B,
    output logic [3:0]               ALU_FUN,
    output logic                     ALU_REQ,
    input  logic [2*WIDTH-1:0]       ALU_RES,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [2*WIDTH-1:0]       OUT_RES,
    output logic [3:0]               OUT_FUN,
    output logic                     BUSY,
    output logic [$clog2(DEPTH):0]   FIFO_COUNT
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 * WIDTH + 4;
    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_d;
    logic          out_valid_d;
    logic          capture;
    logic          pop;
    logic          push;
    logic          flush;

    logic [EW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, empty;
    logic [EW-1:0] head;

`ifdef ALU_CMD_FLUSH_EN
    assign flush = FLUSH;
`else
    assign flush = 1'b0;
`endif

    // Wrap bits differ with equal indices only when the FIFO holds DEPTH entries.
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign FIFO_COUNT = wr_ptr - rd_ptr;
    assign IN_READY   = !full && !flush;
    assign push       = IN_VALID && IN_READY;
    assign head       = mem[rd_ptr[AW-1:0]];
    assign BUSY       = (state_q != IDLE) || !empty;

    // NOTE: storage arrays carry no reset; validity is tracked by the pointers alone.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {IN_A, IN_B, IN_FUN};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = 1'b0;
        out_valid_d = OUT_VALID;
        capture     = 1'b0;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && !flush) begin
                    pop     = 1'b1;
                    req_d   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CW'(ALU_LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    capture     = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (OUT_READY) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ALU_A     <= '0;
            ALU_B     <= '0;
            ALU_FUN   <= '0;
            ALU_REQ   <= 1'b0;
            OUT_VALID <= 1'b0;
            OUT_RES   <= '0;
            OUT_FUN   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ALU_REQ   <= req_d;
            OUT_VALID <= out_valid_d;
            // Operands change only on a pop, so the ALU sees them stable for the whole command.
            if (pop) begin
                ALU_A   <= head[EW-1 -: WIDTH];
                ALU_B   <= head[EW-WIDTH-1 -: WIDTH];
                ALU_FUN <= head[3:0];
            end
            if (capture) begin
                OUT_RES <= ALU_RES;
                OUT_FUN <= ALU_FUN;
            end
        end
    end

endmodule
